ramp_adc_ctrl: RTL

//  Parametrised controller for the comparator-based ramp/integrating ADC.

---
 rtl/ramp_adc_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ramp_adc_ctrl.sv
// ---------------------------------------------------------------------------
// ramp_adc_ctrl
//   Controller for a comparator-based ramp / integrating ADC. Each conversion
//   holds the analog cap in discharge for RST_CYCLES clocks, then releases it
//   to integrate while counting clocks until the comparator trips. The count
//   is latched as a sample and offered to the back end on a valid/ready
//   handshake. If the comparator never trips, the count saturates at MAXC and
//   the sample is flagged with ovf.
//
// Parameters
//   WIDTH       counter / sample width, MAXC = 2**WIDTH-1
//   RST_CYCLES  discharge duration in clocks (>= 1)
//
// Build option
//   CMP_SYNC2_EN  when defined, cmp passes through a 2-flop synchronizer
//                 instead of a single register (one extra cycle of
//                 cmp-to-capture latency, so a given trip instant reads one
//                 count higher). Ports and all other behaviour are unchanged.
//
// Ports
//   clk           in   system clock, posedge
//   rst_n         in   asynchronous active-low reset
//   en            in   1 = convert back-to-back, 0 = stop after current one
//   cmp           in   comparator output, asynchronous to clk
//   reset         out  cap control: 0 = discharge, 1 = integrate (registered)
//   b             out  live ramp count
//   sample        out  captured conversion result
//   sample_valid  out  sample holds an unconsumed result
//   sample_ready  in   consumer accepts sample this cycle
//   ovf           out  sample saturated at MAXC with no trip (qualified by
//                      sample_valid)
//
// FSM states
//   state       | meaning
//   ------------+----------------------------------------------------------
//   IDLE        | stopped, cap discharged, waiting for en
//   DISCHARGE   | cap held in discharge for RST_CYCLES clocks
//   INTEGRATE   | cap integrating, b counting until cmp_s or MAXC
//   HOLD        | result presented, cap discharged, waiting for handshake
// ---------------------------------------------------------------------------
module ramp_adc_ctrl #(
  parameter int WIDTH      = 5,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmp,
  output logic             reset,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DISCHARGE = 2'd1;
  localparam logic [1:0] S_INTEGRATE = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  localparam logic [WIDTH-1:0] MAXC = {WIDTH{1'b1}};

  // Discharge timer is a down-counter: loaded with RST_CYCLES-1 outside
  // DISCHARGE, terminal count zero ends the discharge phase.
  localparam int             TW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0]  TMR_LOAD = TW'(RST_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] tmr;
  logic          tmr_done;
  logic          cmp_s;
  logic          hit_sat;
  logic          capture;
  logic          handshake;

  // -------------------------------------------------------------------------
  // Comparator synchronizer
  // -------------------------------------------------------------------------
`ifdef CMP_SYNC2_EN
  logic cmp_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp;
      cmp_s    <= cmp_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_s <= 1'b0;
    end else begin
      cmp_s <= cmp;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign tmr_done  = (tmr == '0);
  assign hit_sat   = (b == MAXC);
  assign capture   = (state == S_INTEGRATE) && (cmp_s || hit_sat);
  assign handshake = (state == S_HOLD) && sample_valid && sample_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (en)       state_nxt = S_DISCHARGE;
      S_DISCHARGE: if (tmr_done) state_nxt = S_INTEGRATE;
      S_INTEGRATE: if (capture)  state_nxt = S_HOLD;
      S_HOLD:      if (handshake) state_nxt = en ? S_DISCHARGE : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // reset is decoded from the next state so the pin comes straight off a
  // flop and is high exactly while state == INTEGRATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      reset <= 1'b0;
    end else begin
      state <= state_nxt;
      reset <= (state_nxt == S_INTEGRATE);
    end
  end

  // -------------------------------------------------------------------------
  // Discharge timer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= TMR_LOAD;
    end else if (state == S_DISCHARGE) begin
      if (!tmr_done) tmr <= tmr - 1'b1;
    end else begin
      tmr <= TMR_LOAD;
    end
  end

  // -------------------------------------------------------------------------
  // Ramp counter
  //   Counts only while integrating and not capturing; the capture edge
  //   clears it so b reads 0 for the whole of HOLD. Saturation is handled by
  //   the capture branch, so the counter never wraps.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b <= '0;
    end else if ((state == S_INTEGRATE) && !capture) begin
      b <= b + 1'b1;
    end else begin
      b <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Sample register and handshake
  //   A comparator trip takes priority over saturation, so a trip landing
  //   exactly at MAXC reports a real result with ovf=0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      ovf          <= 1'b0;
      sample_valid <= 1'b0;
    end else if (state == S_INTEGRATE) begin
      if (cmp_s) begin
        sample       <= b;
        ovf          <= 1'b0;
        sample_valid <= 1'b1;
      end else if (hit_sat) begin
        sample       <= MAXC;
        ovf          <= 1'b1;
        sample_valid <= 1'b1;
      end
    end else if (handshake) begin
      sample_valid <= 1'b0;
    end
  end

endmodule
